// File: rtl/out_port_fifo.sv
// Output-port FIFO: buffers accumulator values written on OUT strobes and drains them over valid/ready.
// Optional build macro OUT_PORT_TAG_EN adds a PC-address tag stored alongside each entry.
module out_port_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                    clk,
  input  logic                    Reset,
  input  logic                    wr_en_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
`ifdef OUT_PORT_TAG_EN
  input  logic [ADDR_WIDTH-1:0]   wr_addr_i,
  output logic [ADDR_WIDTH-1:0]   out_addr_o,
`endif
  output logic                    full_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    overflow_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [DATA_WIDTH-1:0]   out_data_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
`ifdef OUT_PORT_TAG_EN
  localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;
`else
  localparam int ENTRY_W = DATA_WIDTH;
`endif

  // Pointer wrap relies on DEPTH being a power of two.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || ADDR_WIDTH < 1) begin : g_bad_cfg
    $error("out_port_fifo: DEPTH must be a power of 2 >= 2 and ADDR_WIDTH >= 1");
  end

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               push, pop;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] rd_entry;

`ifdef OUT_PORT_TAG_EN
  assign wr_entry = {wr_addr_i, wr_data_i};
`else
  assign wr_entry = wr_data_i;
`endif

  assign full_o      = (count_q == CNT_W'(DEPTH));
  assign out_valid_o = (count_q != '0);
  assign count_o     = count_q;
  assign overflow_o  = overflow_q;

  // A pop frees a slot in the same edge, so a full FIFO still accepts a write then.
  assign pop  = out_valid_o && out_ready_i;
  assign push = wr_en_i && (!full_o || pop);

  always_comb begin
    mem_d      = mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (push) begin
      mem_d[wr_ptr_q] = wr_entry;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (wr_en_i && !push) begin
      overflow_d = 1'b1;
    end
  end

  // Storage is cleared too so out_data_o reads zero straight out of reset.
  always_ff @(posedge clk) begin
    if (Reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      mem_q      <= mem_d;
    end
  end

  assign rd_entry   = mem_q[rd_ptr_q];
  assign out_data_o = rd_entry[DATA_WIDTH-1:0];
`ifdef OUT_PORT_TAG_EN
  assign out_addr_o = rd_entry[ENTRY_W-1:DATA_WIDTH];
`endif

endmodule

// File: tb/tb_out_port_fifo.sv
// Directed self-checking bench for out_port_fifo (DEPTH 4, 8-bit data).
module tb_out_port_fifo;

  logic       clk;
  logic       Reset;
  logic       wr_en_i;
  logic [7:0] wr_data_i;
  logic       full_o;
  logic [2:0] count_o;
  logic       overflow_o;
  logic       out_valid_o;
  logic       out_ready_i;
  logic [7:0] out_data_o;
`ifdef OUT_PORT_TAG_EN
  logic [5:0] wr_addr_i;
  logic [5:0] out_addr_o;
`endif

  int checks = 0;
  int errors = 0;

  out_port_fifo #(.DATA_WIDTH(8), .DEPTH(4), .ADDR_WIDTH(6)) dut (
    .clk         (clk),
    .Reset       (Reset),
    .wr_en_i     (wr_en_i),
    .wr_data_i   (wr_data_i),
`ifdef OUT_PORT_TAG_EN
    .wr_addr_i   (wr_addr_i),
    .out_addr_o  (out_addr_o),
`endif
    .full_o      (full_o),
    .count_o     (count_o),
    .overflow_o  (overflow_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill4();
    logic [7:0] vals [4];
    vals[0] = 8'd85; vals[1] = 8'd80; vals[2] = 8'd240; vals[3] = 8'd255;
    out_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_en_i = 1'b1;
      wr_data_i = vals[i];
      step();
      chk("fill_count", count_o, i + 1);
      chk("fill_head", out_data_o, 8'd85);
    end
    wr_en_i = 1'b0;
    chk("fill_full", full_o, 1'b1);
  endtask

  task automatic drain_expect(input string tag, input logic [7:0] exp);
    out_ready_i = 1'b1;
    chk({tag, "_valid"}, out_valid_o, 1'b1);
    chk({tag, "_data"}, out_data_o, exp);
    step();
  endtask

  initial begin
    Reset = 1'b1;
    wr_en_i = 1'b1;
    wr_data_i = 8'h55;
    out_ready_i = 1'b0;
`ifdef OUT_PORT_TAG_EN
    wr_addr_i = 6'd0;
`endif
    // Reset overrides a concurrent write.
    step();
    step();
    chk("rst_count", count_o, 0);
    chk("rst_valid", out_valid_o, 1'b0);
    chk("rst_full", full_o, 1'b0);
    chk("rst_ovf", overflow_o, 1'b0);
    chk("rst_data", out_data_o, 8'h00);
    Reset = 1'b0;
    wr_en_i = 1'b0;
    step();
    chk("idle_count", count_o, 0);

    // Empty + ready: no effect.
    out_ready_i = 1'b1;
    step();
    chk("empty_pop_count", count_o, 0);
    chk("empty_pop_valid", out_valid_o, 1'b0);

    // Fill, then overflow attempt.
    fill4();
    wr_en_i = 1'b1;
    wr_data_i = 8'h00;
    step();
    wr_en_i = 1'b0;
    chk("ovf_flag", overflow_o, 1'b1);
    chk("ovf_count", count_o, 4);
    chk("ovf_head", out_data_o, 8'd85);
    step();
    chk("ovf_sticky", overflow_o, 1'b1);
    chk("hold_data", out_data_o, 8'd85);

    drain_expect("drain0", 8'd85);
    chk("drain_count", count_o, 3);
    chk("drain_notfull", full_o, 1'b0);
    drain_expect("drain1", 8'd80);
    drain_expect("drain2", 8'd240);
    drain_expect("drain3", 8'd255);
    chk("drained_valid", out_valid_o, 1'b0);
    chk("drained_count", count_o, 0);
    chk("drained_ovf", overflow_o, 1'b1);
    out_ready_i = 1'b0;

    // Reset clears sticky overflow.
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("rst2_ovf", overflow_o, 1'b0);
    chk("rst2_count", count_o, 0);

    // Full with simultaneous push and pop.
    fill4();
    wr_en_i = 1'b1;
    wr_data_i = 8'hAA;
    out_ready_i = 1'b1;
    step();
    wr_en_i = 1'b0;
    chk("pp_count", count_o, 4);
    chk("pp_full", full_o, 1'b1);
    chk("pp_ovf", overflow_o, 1'b0);
    drain_expect("pp0", 8'd80);
    drain_expect("pp1", 8'd240);
    drain_expect("pp2", 8'd255);
    drain_expect("pp3", 8'hAA);
    chk("pp_empty", out_valid_o, 1'b0);
    chk("pp_ovf_end", overflow_o, 1'b0);

    // Pass-through across pointer wrap.
    out_ready_i = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      wr_en_i = 1'b1;
      wr_data_i = 8'(i);
      step();
      chk("pt_valid", out_valid_o, 1'b1);
      chk("pt_data", out_data_o, i);
      chk("pt_count", count_o, 1);
    end
    wr_en_i = 1'b0;
    step();
    chk("pt_empty", count_o, 0);
    chk("pt_ovf", overflow_o, 1'b0);
    out_ready_i = 1'b0;

    // Stability under back-pressure after wrap.
    wr_en_i = 1'b1;
    wr_data_i = 8'h3C;
    step();
    wr_data_i = 8'hC3;
    step();
    wr_en_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_data", out_data_o, 8'h3C);
      chk("bp_count", count_o, 2);
    end
    drain_expect("bp0", 8'h3C);
    drain_expect("bp1", 8'hC3);
    chk("bp_empty", out_valid_o, 1'b0);
    out_ready_i = 1'b0;

`ifdef OUT_PORT_TAG_EN
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("tag_rst_addr", out_addr_o, 6'd0);
    wr_en_i = 1'b1;
    wr_data_i = 8'd85;
    wr_addr_i = 6'd45;
    step();
    wr_data_i = 8'd80;
    wr_addr_i = 6'd46;
    step();
    wr_en_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("tag_hold_addr", out_addr_o, 6'd45);
      chk("tag_hold_data", out_data_o, 8'd85);
      step();
    end
    out_ready_i = 1'b1;
    step();
    chk("tag_next_addr", out_addr_o, 6'd46);
    chk("tag_next_data", out_data_o, 8'd80);
    step();
    chk("tag_empty", out_valid_o, 1'b0);
    out_ready_i = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
